// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ready access per load or
// store, stalls the pipeline until it completes or times out, returns load data.
module mem_access_ctrl #(
  parameter int word_width     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [word_width-1:0] ALUResultM,
  input  logic [word_width-1:0] WriteDataM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [word_width-1:0] mem_addr,
  output logic [word_width-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [word_width-1:0] mem_rdata,
  output logic                  StallMem,
  output logic [word_width-1:0] ReadDataM,
  output logic                  mem_fault,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_req;
  logic                  r_we;
  logic [word_width-1:0] r_addr;
  logic [word_width-1:0] r_wdata;
  logic [word_width-1:0] r_rdata;
  logic                  r_fault;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_acc;
  logic                  w_timeout;

  assign w_acc     = MemWriteM | (ResultSrcM == 2'b01);
  // A zero timeout parameter disables the abort path entirely.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    StallMem     = 1'b0;
    case (r_state)
      S_IDLE: begin
        StallMem = w_acc;
        if (w_acc) w_next_state = S_BUSY;
      end
      S_BUSY: begin
        StallMem = 1'b1;
        if (mem_ready || w_timeout) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_req   <= 1'b1;
            r_we    <= MemWriteM;
            r_addr  <= ALUResultM;
            r_wdata <= WriteDataM;
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          // Ready on the timeout cycle still counts as a normal completion.
          if (mem_ready) begin
            r_req   <= 1'b0;
            r_rdata <= r_we ? '0 : mem_rdata;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_rdata <= '0;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req     = r_req;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign ReadDataM   = r_rdata;
  assign mem_fault   = r_fault;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized accesses
// checked against a per-transaction latency/result model.
module tb_mem_access_ctrl;

  localparam int T = 16;
  localparam logic [1:0] IDLE_ENC = 2'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        StallMem;
  logic [31:0] ReadDataM;
  logic        mem_fault;
  logic [1:0]  o_dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rd;

  mem_access_ctrl #(.word_width(32), .TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .StallMem(StallMem),
    .ReadDataM(ReadDataM), .mem_fault(mem_fault), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  // One complete access: IDLE cycle, BUSY cycles, DONE cycle.
  // The model: ready after `delay` wait cycles, aborted once T BUSY cycles elapse.
  task automatic run_access(input logic st, input logic ld, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int delay, input string nm);
    int          busy;
    int          stalls;
    logic        exp_fault;
    logic [31:0] exp_rd;
    exp_fault = (T != 0) && (delay >= T);
    busy      = exp_fault ? T : delay + 1;
    exp_rd    = (exp_fault || st) ? 32'h0 : rdata;

    @(negedge clk);
    MemWriteM  = st;
    ResultSrcM = ld ? 2'b01 : 2'(2 * $urandom_range(0, 1));
    ALUResultM = addr;
    WriteDataM = wdata;
    mem_ready  = 1'($urandom);
    mem_rdata  = $urandom;
    #1;
    stalls = int'(StallMem);
    n_tests++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL %s idle_req got=%b exp=0", nm, mem_req);
    end

    for (int k = 0; k < busy; k++) begin
      @(negedge clk);
      mem_ready = (k == delay);
      mem_rdata = (k == delay) ? rdata : $urandom;
      #1;
      stalls += int'(StallMem);
      n_tests++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, st, addr, wdata}) begin
        n_fail++;
        $display("FAIL %s busy%0d_bus got=%b/%b/%h/%h exp=1/%b/%h/%h", nm, k,
                 mem_req, mem_we, mem_addr, mem_wdata, st, addr, wdata);
      end
      n_tests++;
      if (mem_fault !== 1'b0) begin
        n_fail++; $display("FAIL %s busy%0d_fault got=%b exp=0", nm, k, mem_fault);
      end
    end

    @(negedge clk);
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    #1;
    n_tests++;
    if ({StallMem, mem_req} !== 2'b00) begin
      n_fail++; $display("FAIL %s done_stall_req got=%b%b exp=00", nm, StallMem, mem_req);
    end
    n_tests++;
    if (ReadDataM !== exp_rd) begin
      n_fail++; $display("FAIL %s done_rdata got=%h exp=%h", nm, ReadDataM, exp_rd);
    end
    n_tests++;
    if (mem_fault !== exp_fault) begin
      n_fail++; $display("FAIL %s done_fault got=%b exp=%b", nm, mem_fault, exp_fault);
    end
    n_tests++;
    if (stalls !== busy + 1) begin
      n_fail++; $display("FAIL %s stall_cycles got=%0d exp=%0d", nm, stalls, busy + 1);
    end
    last_rd = exp_rd;
  endtask

  task automatic idle_cycle(input string nm);
    @(negedge clk);
    MemWriteM  = 1'b0;
    ResultSrcM = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'(2 + $urandom_range(0, 1));
    ALUResultM = $urandom;
    WriteDataM = $urandom;
    mem_ready  = 1'($urandom);
    mem_rdata  = $urandom;
    #1;
    n_tests++;
    if ({StallMem, mem_req, mem_fault, ReadDataM} !== {3'b000, last_rd}) begin
      n_fail++;
      $display("FAIL %s idle got=stall%b req%b fault%b rd=%h exp=stall0 req0 fault0 rd=%h",
               nm, StallMem, mem_req, mem_fault, ReadDataM, last_rd);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    ALUResultM = 32'hCAFE_0000;
    WriteDataM = 32'h1111_2222;
    mem_ready  = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, mem_fault, o_dbg_state}
        !== {2'b00, 96'h0, 1'b0, IDLE_ENC}) begin
      n_fail++;
      $display("FAIL reset_values got=%b%b %h %h %h %b st=%0d exp=all zero, IDLE",
               mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, mem_fault, o_dbg_state);
    end
    @(negedge clk);
    reset      = 1'b0;
    ResultSrcM = 2'b00;
    #1;
    n_tests++;
    if (StallMem !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall_noacc got=%b exp=0", StallMem);
    end
    ResultSrcM = 2'b01;
    #1;
    n_tests++;
    if (StallMem !== 1'b1) begin
      n_fail++; $display("FAIL reset_stall_acc got=%b exp=1", StallMem);
    end
    ResultSrcM = 2'b00;
    last_rd    = 32'h0;
    idle_cycle("post_reset");
  endtask

  task automatic test_load();
    run_access(1'b0, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 0, "load_fast");
    idle_cycle("load_fast_after");
  endtask

  task automatic test_store();
    run_access(1'b1, 1'b0, 32'h40, 32'h12345678, 32'h9999_9999, 3, "store_wait3");
    idle_cycle("store_after");
    run_access(1'b1, 1'b1, 32'h44, 32'hA5A5_5A5A, 32'h7777_7777, 1, "store_priority");
    idle_cycle("store_priority_after");
  endtask

  task automatic test_timeout();
    run_access(1'b0, 1'b1, 32'h200, 32'h0, 32'h0BAD_F00D, 100, "timeout_load");
    idle_cycle("timeout_after");
    run_access(1'b0, 1'b1, 32'h204, 32'h0, 32'h600D_CAFE, T - 1, "ready_on_timeout");
    idle_cycle("ready_on_timeout_after");
    run_access(1'b1, 1'b0, 32'h208, 32'h3333_4444, 32'h0, T, "timeout_store");
    idle_cycle("timeout_store_after");
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b1, 32'h300, 32'h0, 32'h1357_9BDF, 0, "b2b_first");
    run_access(1'b0, 1'b1, 32'h304, 32'h0, 32'h2468_ACE0, 0, "b2b_second");
    idle_cycle("b2b_after");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    ALUResultM = 32'h400;
    mem_ready  = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    ResultSrcM = 2'b00;
    #1;
    n_tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, mem_fault, StallMem, o_dbg_state}
        !== {2'b00, 96'h0, 2'b00, IDLE_ENC}) begin
      n_fail++;
      $display("FAIL reset_mid got=%b%b %h %h %h f%b s%b st=%0d exp=all zero, IDLE",
               mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, mem_fault, StallMem,
               o_dbg_state);
    end
    last_rd = 32'h0;
    idle_cycle("reset_mid_after");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int   kind;
      int   dly;
      kind = $urandom_range(0, 2);
      dly  = ($urandom_range(0, 4) == 0) ? $urandom_range(T - 2, T + 3) : $urandom_range(0, 5);
      run_access(kind != 0, kind != 1, $urandom, $urandom, $urandom, dly, "random");
      if ($urandom_range(0, 1) == 1) idle_cycle("random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
